ticked_reg: RTL and testbench

// - WIDTH-bit register with load and shift modes, updated only on a

---
 rtl/ticked_reg.sv | 103 ++++++++++
 tb/tb_ticked_reg.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ticked_reg.sv
// ticked_reg: WIDTH-bit register with hold / parallel load / shift left /
// shift right modes. Updates commit only on a prescaled tick generated from
// clk by an internal counter, so no derived clock is ever created.
//
// Ports
//   clk      system clock, everything on posedge
//   reset    synchronous active-high reset (cnt, q, updated)
//   restart  synchronous prescaler clear; q is left alone
//   en       update enable, looked at only on tick cycles
//   mode     00 hold, 01 load d, 10 shift left, 11 shift right
//   d        parallel load data
//   ser_in   serial bit entering at q[0] (shift left) or q[WIDTH-1] (shift right)
//   tick     high on the cycle where the prescaler sits at DIV-1 (combinational)
//   q        register value
//   updated  one-cycle pulse, aligned with q, after any load/shift
module ticked_reg #(
    parameter int unsigned       WIDTH     = 8,
    parameter int unsigned       DIV       = 4,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    output logic             tick,
    output logic [WIDTH-1:0] q,
    output logic             updated
);

    localparam int unsigned    CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_SHR  = 2'b11;

    logic [CNT_W-1:0] cnt;
    logic             at_max;
    logic [WIDTH-1:0] q_next;
    logic             updated_next;

    assign at_max = (cnt == CNT_MAX);

    // Tick is suppressed while reset is held so nothing commits during reset.
    assign tick = at_max && !reset;

    // Prescaler: 0..DIV-1 then wrap; with DIV=1 it never leaves 0.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cnt <= '0;
        end else if (at_max) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Next register value; restart on a tick cycle drops the update.
    always_comb begin
        q_next       = q;
        updated_next = 1'b0;
        if (tick && en && !restart) begin
            case (mode)
                MODE_HOLD: begin
                    q_next       = q;
                    updated_next = 1'b0;
                end
                MODE_LOAD: begin
                    q_next       = d;
                    updated_next = 1'b1;
                end
                MODE_SHL: begin
                    q_next       = {q[WIDTH-2:0], ser_in};
                    updated_next = 1'b1;
                end
                MODE_SHR: begin
                    q_next       = {ser_in, q[WIDTH-1:1]};
                    updated_next = 1'b1;
                end
                default: begin
                    q_next       = q;
                    updated_next = 1'b0;
                end
            endcase
        end
    end

    // Register and update flag commit together.
    always_ff @(posedge clk) begin
        if (reset) begin
            q       <= RESET_VAL;
            updated <= 1'b0;
        end else begin
            q       <= q_next;
            updated <= updated_next;
        end
    end

endmodule

// File: tb/tb_ticked_reg.sv
// Bench for ticked_reg: a DIV=4 instance checked against a cycle-level
// reference model, plus a DIV=1 instance checked directly.
module tb_ticked_reg;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       restart = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] d = 8'h00;
    logic       ser_in = 1'b0;
    logic       tick;
    logic [7:0] q;
    logic       updated;

    logic       reset1 = 1'b1;
    logic       restart1 = 1'b0;
    logic       en1 = 1'b0;
    logic [1:0] mode1 = 2'b00;
    logic [7:0] d1 = 8'h00;
    logic       ser_in1 = 1'b0;
    logic       tick1;
    logic [7:0] q1;
    logic       updated1;

    int checks = 0;
    int failures = 0;

    // Reference state: phase = cycles since last clear, modulo DIV.
    int         mph = 0;
    logic [7:0] mq = 8'h00;
    logic       mupd = 1'b0;

    always #5 clk = ~clk;

    ticked_reg #(.WIDTH(8), .DIV(DIV), .RESET_VAL(8'h00)) u_dut (
        .clk(clk), .reset(reset), .restart(restart), .en(en), .mode(mode),
        .d(d), .ser_in(ser_in), .tick(tick), .q(q), .updated(updated)
    );

    ticked_reg #(.WIDTH(8), .DIV(1), .RESET_VAL(8'h00)) u_dut1 (
        .clk(clk), .reset(reset1), .restart(restart1), .en(en1), .mode(mode1),
        .d(d1), .ser_in(ser_in1), .tick(tick1), .q(q1), .updated(updated1)
    );

    // Reference model of the register rules, using plain arithmetic.
    always @(posedge clk) begin
        if (reset) begin
            mph  <= 0;
            mq   <= 8'h00;
            mupd <= 1'b0;
        end else if (restart) begin
            mph  <= 0;
            mupd <= 1'b0;
        end else begin
            mph  <= (mph + 1) % DIV;
            mupd <= 1'b0;
            if (mph == DIV - 1 && en && mode != 2'b00) begin
                mupd <= 1'b1;
                if (mode == 2'b01) mq <= d;
                else if (mode == 2'b10) mq <= 8'((int'(mq) * 2 + int'(ser_in)) % 256);
                else mq <= 8'(int'(mq) / 2 + int'(ser_in) * 128);
            end
        end
    end

    function automatic logic exp_tick();
        return (!reset) && (mph == DIV - 1);
    endfunction

    // Idle until the model says the current cycle is a tick; leaves the bench
    // at that cycle's negedge with inputs not yet driven.
    task automatic wait_tick();
        int n = 0;
        @(negedge clk);
        while (mph != DIV - 1 && n < 2 * DIV + 2) begin
            reset = 1'b0; restart = 1'b0; en = 1'b0; mode = 2'b00;
            @(negedge clk);
            n++;
        end
        if (mph != DIV - 1) begin
            checks++; failures++;
            $display("FAIL wait_tick: no tick within %0d cycles", n);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (q !== 8'h00 || updated !== 1'b0 || tick !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold: q=%h updated=%b tick=%b, want q=00 updated=0 tick=0", q, updated, tick);
            end
        end
        reset = 1'b0; en = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if (tick !== ((i % 4) == 3) || q !== 8'h00 || updated !== 1'b0) begin
                failures++;
                $display("FAIL reset_release c%0d: tick=%b q=%h updated=%b, want tick=%b q=00 updated=0",
                         i, tick, q, updated, (i % 4) == 3);
            end
        end
    endtask

    task automatic test_load();
        wait_tick();
        en = 1'b1; mode = 2'b01; d = 8'hA5;
        #1;
        checks++;
        if (tick !== 1'b1) begin
            failures++;
            $display("FAIL load_tick: tick=%b want 1", tick);
        end
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            en = 1'b1; mode = 2'b01;
            d = (mph == DIV - 1) ? 8'hA5 : 8'($urandom);
            #1;
            checks++;
            if (q !== 8'hA5 || updated !== mupd || q !== mq || tick !== exp_tick()) begin
                failures++;
                $display("FAIL load c%0d: q=%h updated=%b tick=%b, want q=A5 updated=%b tick=%b",
                         i, q, updated, tick, mupd, exp_tick());
            end
            if (i == 1 || i == 2) begin
                checks++;
                if (updated !== (i == 1)) begin
                    failures++;
                    $display("FAIL load_pulse c%0d: updated=%b want %b", i, updated, i == 1);
                end
            end
        end
    endtask

    task automatic test_shift();
        logic [7:0] exp_seq [4];
        exp_seq[0] = 8'h03; exp_seq[1] = 8'h07; exp_seq[2] = 8'h0F; exp_seq[3] = 8'h07;
        wait_tick();
        en = 1'b1; mode = 2'b01; d = 8'h81;
        for (int k = 0; k < 4; k++) begin
            wait_tick();
            en = 1'b1;
            mode = (k < 3) ? 2'b10 : 2'b11;
            ser_in = (k < 3) ? 1'b1 : 1'b0;
            d = 8'($urandom);
            @(negedge clk);
            #1;
            checks++;
            if (q !== exp_seq[k] || updated !== 1'b1 || q !== mq) begin
                failures++;
                $display("FAIL shift step%0d: q=%h updated=%b, want q=%h updated=1", k, q, updated, exp_seq[k]);
            end
        end
    endtask

    task automatic test_restart();
        wait_tick();
        restart = 1'b1; en = 1'b1; mode = 2'b01; d = 8'hFF;
        #1;
        checks++;
        if (tick !== 1'b1) begin
            failures++;
            $display("FAIL restart_tick: tick=%b want 1", tick);
        end
        for (int i = 1; i <= DIV; i++) begin
            @(negedge clk);
            restart = 1'b0; en = 1'b1; mode = 2'b01; d = 8'hFF;
            #1;
            checks++;
            if (tick !== (i == DIV) || q !== 8'h07 || (i == 1 && updated !== 1'b0)) begin
                failures++;
                $display("FAIL restart c%0d: tick=%b q=%h updated=%b, want tick=%b q=07 updated=0",
                         i, tick, q, updated, i == DIV);
            end
        end
    endtask

    task automatic test_reset_on_tick();
        wait_tick();
        reset = 1'b1; en = 1'b1; mode = 2'b01; d = 8'h3C;
        #1;
        checks++;
        if (tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_on_tick: tick=%b want 0", tick);
        end
        @(negedge clk);
        reset = 1'b0; en = 1'b0;
        #1;
        checks++;
        if (q !== 8'h00 || updated !== 1'b0 || tick !== exp_tick()) begin
            failures++;
            $display("FAIL reset_on_tick_after: q=%h updated=%b tick=%b, want q=00 updated=0 tick=%b",
                     q, updated, tick, exp_tick());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            reset   = ($urandom_range(63) == 0);
            restart = ($urandom_range(11) == 0);
            en      = ($urandom_range(3) != 0);
            mode    = 2'($urandom);
            d       = 8'($urandom);
            ser_in  = 1'($urandom);
            #1;
            checks++;
            if (tick !== exp_tick() || q !== mq || updated !== mupd) begin
                failures++;
                $display("FAIL random c%0d: tick=%b q=%h updated=%b, want tick=%b q=%h updated=%b",
                         i, tick, q, updated, exp_tick(), mq, mupd);
            end
        end
        @(negedge clk);
        reset = 1'b0; restart = 1'b0; en = 1'b0;
    endtask

    task automatic test_div1();
        logic [7:0] prev_d;
        @(negedge clk);
        reset1 = 1'b1;
        #1;
        checks++;
        if (tick1 !== 1'b0) begin
            failures++;
            $display("FAIL div1_reset_tick: tick=%b want 0", tick1);
        end
        @(negedge clk);
        reset1 = 1'b0; en1 = 1'b1; mode1 = 2'b01; d1 = 8'($urandom);
        #1;
        checks++;
        if (tick1 !== 1'b1 || q1 !== 8'h00) begin
            failures++;
            $display("FAIL div1_start: tick=%b q=%h, want tick=1 q=00", tick1, q1);
        end
        for (int i = 0; i < 10; i++) begin
            prev_d = d1;
            @(negedge clk);
            d1 = 8'($urandom);
            #1;
            checks++;
            if (q1 !== prev_d || updated1 !== 1'b1 || tick1 !== 1'b1) begin
                failures++;
                $display("FAIL div1 c%0d: q=%h updated=%b tick=%b, want q=%h updated=1 tick=1",
                         i, q1, updated1, tick1, prev_d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_shift();
        test_restart();
        test_reset_on_tick();
        test_random();
        test_div1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
